// File: rtl/fcpu_support.sv
// fcpu_support: dual-port 2048x8 RAM, 1 kHz / 100 Hz / CPU-step tick timebase, button debouncers.
// Define FCPU_DEBOUNCE_EN to build the stability-counter debouncers; otherwise buttons are only synchronized.
module fcpu_tick #(
    parameter int D = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int W = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q;
    logic         wrap;

    assign wrap   = (cnt_q == W'(D - 1));
    assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    assign tick_o = tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end
endmodule

module fcpu_support #(
    parameter int    CLK_HZ    = 50_000_000,
    parameter int    CPU_HZ    = 2,
    parameter int    DEB_N     = 8,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        but1,
    input  logic        but2,
    output logic        but1_db,
    output logic        but2_db,
    output logic        tick_1k,
    output logic        tick_100,
    output logic        tick_cpu,
    input  logic [10:0] addr_a,
    input  logic [7:0]  data_a,
    input  logic        we_a,
    output logic [7:0]  q_a,
    input  logic [10:0] addr_b,
    input  logic [7:0]  data_b,
    input  logic        we_b,
    output logic [7:0]  q_b
);
    localparam int D1K  = CLK_HZ / 1000;
    localparam int D100 = CLK_HZ / 100;
    localparam int DCPU = CLK_HZ / CPU_HZ;

    if (D1K < 2 || D100 < 2 || DCPU < 2) begin : g_bad_div
        $error("fcpu_support: tick divisor below 2");
    end

    fcpu_tick #(.D(D1K))  u_t1k  (.clk(clk), .rst(rst), .tick_o(tick_1k));
    fcpu_tick #(.D(D100)) u_t100 (.clk(clk), .rst(rst), .tick_o(tick_100));
    fcpu_tick #(.D(DCPU)) u_tcpu (.clk(clk), .rst(rst), .tick_o(tick_cpu));

    logic [1:0] s1_q, s2_q;
    logic [1:0] db_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= {but2, but1};
            s2_q <= s1_q;
        end
    end

`ifdef FCPU_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_N + 1);

    logic [1:0]    db_q, db_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    // A change is accepted on the DEB_N-th consecutive differing 1 kHz sample.
    always_comb begin
        db_d = db_q;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = cnt_q[b];
            if (tick_1k) begin
                if (s2_q[b] != db_q[b]) begin
                    if (cnt_q[b] == CW'(DEB_N - 1)) begin
                        db_d[b]  = s2_q[b];
                        cnt_d[b] = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end else begin
                    cnt_d[b] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q  <= 2'b00;
            cnt_q <= '{default: '0};
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_w = db_q;
`else
    assign db_w = s2_q;
`endif

    assign but1_db = db_w[0];
    assign but2_db = db_w[1];

    logic [7:0] mem_q [0:2047];
    logic [7:0] q_a_q, q_b_q;

    initial begin
        for (int i = 0; i < 2048; i++) mem_q[i] = 8'h00;
    end

    // Port A is applied last so it wins a same-address collision.
    always @(posedge clk) begin
        if (we_b) mem_q[addr_b] <= data_b;
        if (we_a) mem_q[addr_a] <= data_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a_q <= 8'h00;
            q_b_q <= 8'h00;
        end else begin
            q_a_q <= mem_q[addr_a];
            q_b_q <= mem_q[addr_b];
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;
endmodule

// File: tb/tb_fcpu_support.sv
// Scoreboard bench for fcpu_support: stimulus queues expectations, one monitor checks them.
module tb_fcpu_support;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        but1 = 1'b0, but2 = 1'b0;
    logic        but1_db, but2_db, tick_1k, tick_100, tick_cpu;
    logic [10:0] addr_a = '0, addr_b = '0;
    logic [7:0]  data_a = '0, data_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0;
    logic [7:0]  q_a, q_b;

    fcpu_support #(
        .CLK_HZ(100_000), .CPU_HZ(10), .DEB_N(8), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .but1(but1), .but2(but2),
        .but1_db(but1_db), .but2_db(but2_db),
        .tick_1k(tick_1k), .tick_100(tick_100), .tick_cpu(tick_cpu),
        .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } exp_t;
    typedef struct { int lo; int hi; int val; } ev_t;

    exp_t qa[$], qb[$];
    int   t1[$], t2[$], t3[$];
    ev_t  e1[$], e2[$];
    int   cyc = 0;
    int   errors = 0, checks = 0;
    bit   done = 1'b0;
    logic p1 = 1'b0, p2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void chkw(string nm, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got cycle %0d required %0d..%0d", nm, act, lo, hi);
        end
    endfunction

    always @(negedge clk) begin
        if (cyc == 3) begin
            chk("rst tick_1k", tick_1k, 0);
            chk("rst tick_100", tick_100, 0);
            chk("rst tick_cpu", tick_cpu, 0);
            chk("rst but1_db", but1_db, 0);
            chk("rst but2_db", but2_db, 0);
        end
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            chk("q_a", q_a, qa[0].val);
            void'(qa.pop_front());
        end
        if (qb.size() > 0 && qb[0].cyc == cyc) begin
            chk("q_b", q_b, qb[0].val);
            void'(qb.pop_front());
        end
        if (t1.size() > 0 && t1[0] == cyc) begin
            chk("tick_1k", tick_1k, 1);
            void'(t1.pop_front());
        end else if (tick_1k) chk("tick_1k unexpected", tick_1k, 0);
        if (t2.size() > 0 && t2[0] == cyc) begin
            chk("tick_100", tick_100, 1);
            void'(t2.pop_front());
        end else if (tick_100) chk("tick_100 unexpected", tick_100, 0);
        if (t3.size() > 0 && t3[0] == cyc) begin
            chk("tick_cpu", tick_cpu, 1);
            void'(t3.pop_front());
        end else if (tick_cpu) chk("tick_cpu unexpected", tick_cpu, 0);
        if (but1_db !== p1) begin
            if (e1.size() > 0) begin
                chkw("but1_db edge", cyc, e1[0].lo, e1[0].hi);
                chk("but1_db level", but1_db, e1[0].val);
                void'(e1.pop_front());
            end else chk("but1_db unexpected", but1_db, p1);
            p1 = but1_db;
        end else if (e1.size() > 0 && cyc > e1[0].hi) begin
            chkw("but1_db late", cyc, e1[0].lo, e1[0].hi);
            void'(e1.pop_front());
        end
        if (but2_db !== p2) begin
            if (e2.size() > 0) begin
                chkw("but2_db edge", cyc, e2[0].lo, e2[0].hi);
                chk("but2_db level", but2_db, e2[0].val);
                void'(e2.pop_front());
            end else chk("but2_db unexpected", but2_db, p2);
            p2 = but2_db;
        end else if (e2.size() > 0 && cyc > e2[0].hi) begin
            chkw("but2_db late", cyc, e2[0].lo, e2[0].hi);
            void'(e2.pop_front());
        end
        if (done) begin
            chk("tick_1k pending", t1.size(), 0);
            chk("tick_100 pending", t2.size(), 0);
            chk("tick_cpu pending", t3.size(), 0);
            chk("q_a pending", qa.size(), 0);
            chk("q_b pending", qb.size(), 0);
            chk("but1 pending", e1.size(), 0);
            chk("but2 pending", e2.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic ram(input logic wa, input logic [10:0] aa,
                       input logic [7:0] da, input int xa,
                       input logic wb, input logic [10:0] ab,
                       input logic [7:0] db, input int xb);
        we_a = wa; addr_a = aa; data_a = da;
        we_b = wb; addr_b = ab; data_b = db;
        if (xa >= 0) qa.push_back('{cyc + 1, xa});
        if (xb >= 0) qb.push_back('{cyc + 1, xb});
        @(negedge clk);
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    int c0, c1, c, e, h, r;

    initial begin
        qa.push_back('{3, 0});
        qb.push_back('{3, 0});
        repeat (5) @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        ram(1, 11'h7FF, 8'hA5, 8'h00, 0, 11'h000, 8'h00, 8'h00);
        ram(0, 11'h7FF, 8'h00, 8'hA5, 0, 11'h7FF, 8'h00, 8'hA5);
        ram(1, 11'h010, 8'h11, 8'h00, 1, 11'h010, 8'h22, 8'h00);
        ram(0, 11'h010, 8'h00, 8'h11, 0, 11'h010, 8'h00, 8'h11);
        ram(1, 11'h020, 8'h3C, 8'h00, 0, 11'h020, 8'h00, 8'h00);
        ram(1, 11'h021, 8'h55, 8'h00, 0, 11'h020, 8'h00, 8'h3C);
        ram(0, 11'h100, 8'h00, 8'h00, 1, 11'h100, 8'h77, 8'h00);
        ram(0, 11'h100, 8'h00, 8'h77, 0, 11'h021, 8'h00, 8'h55);
        while (cyc < c0 + 50) @(negedge clk);
        rst = 1'b1;
        ram(1, 11'h200, 8'h99, 8'h00, 0, 11'h7FF, 8'h00, 8'h00);
        rst = 1'b0;
        c1 = cyc;
        for (int k = 1; k <= 205; k++) t1.push_back(c1 + 100 * k);
        for (int k = 1; k <= 20; k++) t2.push_back(c1 + 1000 * k);
        for (int k = 1; k <= 2; k++) t3.push_back(c1 + 10000 * k);
        ram(0, 11'h7FF, 8'h00, 8'hA5, 0, 11'h200, 8'h00, 8'h99);

        while (cyc < c1 + 20) @(negedge clk);
        c = cyc;
        but2 = 1'b1;
`ifndef FCPU_DEBOUNCE_EN
        e2.push_back('{c + 2, c + 2, 1});
        e2.push_back('{c + 3, c + 3, 0});
`endif
        @(negedge clk);
        but2 = 1'b0;

        while (cyc < c1 + 100) @(negedge clk);
        e = cyc;
        but1 = 1'b1;
`ifndef FCPU_DEBOUNCE_EN
        e1.push_back('{e + 2, e + 2, 1});
        e1.push_back('{e + 302, e + 302, 0});
`endif
        repeat (300) @(negedge clk);
        but1 = 1'b0;

        while (cyc < c1 + 900) @(negedge clk);
        h = cyc;
        but1 = 1'b1;
`ifdef FCPU_DEBOUNCE_EN
        e1.push_back('{h + 700, h + 900, 1});
`else
        e1.push_back('{h + 2, h + 2, 1});
`endif
        while (cyc < c1 + 2900) @(negedge clk);
        r = cyc;
        but1 = 1'b0;
`ifdef FCPU_DEBOUNCE_EN
        e1.push_back('{r + 700, r + 900, 0});
`else
        e1.push_back('{r + 2, r + 2, 0});
`endif
        while (cyc < c1 + 20550) @(negedge clk);
        done = 1'b1;
    end
endmodule
